uart_frame_codec: RTL and testbench

Framing layer that sits on the user side of the UART core (FIFO-buffered RX/TX byte interface). On the receive side it pops bytes from the RX FIFO and parses framed packets: SOF, TYPE, LEN, PAYLOAD[LEN], CHK. On the transmit side it builds the same frame format from a parallel request and pushes the bytes into the TX FIFO. The game logic therefore exchanges whole checksummed messages instead of raw bytes.

---
 rtl/uart_frame_codec.sv | 204 ++++++++++++++++++++
 tb/tb_uart_frame_codec.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_codec.sv
// Frame codec between the game logic and the UART byte FIFOs.
// Frame format: SOF, TYPE, LEN, PAYLOAD[LEN], CHK (two's complement of the byte sum).
module uart_frame_codec #(
  parameter int         MAX_LEN = 4,
  parameter int         LEN_W   = 3,
  parameter logic [7:0] SOF     = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_empty,
  input  logic [7:0]             r_data,
  output logic                   rd_uart,
  input  logic                   tx_full,
  output logic                   wr_uart,
  output logic [7:0]             w_data,
  output logic                   frm_valid,
  output logic                   frm_err,
  output logic [7:0]             frm_type,
  output logic [LEN_W-1:0]       frm_len,
  output logic [8*MAX_LEN-1:0]   frm_payload,
  input  logic                   send_req,
  input  logic [7:0]             send_type,
  input  logic [LEN_W-1:0]       send_len,
  input  logic [8*MAX_LEN-1:0]   send_payload,
  output logic                   send_busy,
  output logic                   send_done
);

  localparam int               PW    = 8*MAX_LEN;
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  // ---------------- receive path ----------------
  typedef enum logic [2:0] {R_IDLE, R_TYPE, R_LEN, R_PAY, R_CHK} rx_st_t;

  rx_st_t           rx_st, rx_nxt;
  logic [7:0]       rx_type;
  logic [7:0]       rx_sum;
  logic [LEN_W-1:0] rx_len;
  logic [LEN_W-1:0] rx_idx;
  logic [PW-1:0]    rx_buf;
  logic [PW-1:0]    rx_masked;
  logic [7:0]       rx_fin;
  logic             len_bad;

  assign rd_uart = ~rx_empty & ~rst;
  assign rx_fin  = rx_sum + r_data;
  assign len_bad = (r_data > 8'(MAX_LEN));

  // Stale bytes from longer earlier frames stay in rx_buf; hide them at commit.
  always_comb begin
    rx_masked = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (LEN_W'(i) < rx_len) rx_masked[8*i +: 8] = rx_buf[8*i +: 8];
  end

  always_comb begin
    rx_nxt = rx_st;
    if (rd_uart) begin
      case (rx_st)
        R_IDLE: if (r_data == SOF) rx_nxt = R_TYPE;
        R_TYPE: rx_nxt = R_LEN;
        R_LEN: begin
          if (len_bad)             rx_nxt = R_IDLE;
          else if (r_data == 8'h0) rx_nxt = R_CHK;
          else                     rx_nxt = R_PAY;
        end
        R_PAY:   if (rx_idx == rx_len - 1'b1) rx_nxt = R_CHK;
        R_CHK:   rx_nxt = R_IDLE;
        default: rx_nxt = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st       <= R_IDLE;
      rx_type     <= '0;
      rx_sum      <= '0;
      rx_len      <= '0;
      rx_idx      <= '0;
      rx_buf      <= '0;
      frm_valid   <= 1'b0;
      frm_err     <= 1'b0;
      frm_type    <= '0;
      frm_len     <= '0;
      frm_payload <= '0;
    end else begin
      rx_st     <= rx_nxt;
      frm_valid <= 1'b0;
      frm_err   <= 1'b0;
      if (rd_uart) begin
        case (rx_st)
          R_TYPE: begin
            rx_type <= r_data;
            rx_sum  <= r_data;
          end
          R_LEN: begin
            rx_len  <= r_data[LEN_W-1:0];
            rx_idx  <= '0;
            rx_sum  <= rx_fin;
            frm_err <= len_bad;
          end
          R_PAY: begin
            for (int i = 0; i < MAX_LEN; i++)
              if (rx_idx == LEN_W'(i)) rx_buf[8*i +: 8] <= r_data;
            rx_idx <= rx_idx + 1'b1;
            rx_sum <= rx_fin;
          end
          R_CHK: begin
            if (rx_fin == 8'h00) begin
              frm_valid   <= 1'b1;
              frm_type    <= rx_type;
              frm_len     <= rx_len;
              frm_payload <= rx_masked;
            end else begin
              frm_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- transmit path ----------------
  typedef enum logic [2:0] {T_IDLE, T_SOF, T_TYPE, T_LEN, T_PAY, T_CHK} tx_st_t;

  typedef struct packed {
    logic [7:0]       typ;
    logic [LEN_W-1:0] len;
    logic [PW-1:0]    pay;
  } tx_req_t;

  tx_st_t           tx_st, tx_nxt;
  tx_req_t          tx_req;
  logic [LEN_W-1:0] tx_idx;
  logic [7:0]       tx_sum;
  logic [7:0]       tx_chk;
  logic [7:0]       tx_pay_byte;

  assign send_busy = (tx_st != T_IDLE);
  assign wr_uart   = send_busy & ~tx_full & ~rst;

  always_comb begin
    tx_sum      = tx_req.typ + 8'(tx_req.len);
    tx_pay_byte = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < tx_req.len) tx_sum = tx_sum + tx_req.pay[8*i +: 8];
      if (tx_idx == LEN_W'(i))    tx_pay_byte = tx_req.pay[8*i +: 8];
    end
    tx_chk = 8'h00 - tx_sum;
  end

  // Byte states only advance on an actual push, so backpressure just holds the byte.
  always_comb begin
    tx_nxt = tx_st;
    w_data = '0;
    case (tx_st)
      T_IDLE: if (send_req) tx_nxt = T_SOF;
      T_SOF: begin
        w_data = SOF;
        if (wr_uart) tx_nxt = T_TYPE;
      end
      T_TYPE: begin
        w_data = tx_req.typ;
        if (wr_uart) tx_nxt = T_LEN;
      end
      T_LEN: begin
        w_data = 8'(tx_req.len);
        if (wr_uart) tx_nxt = (tx_req.len == '0) ? T_CHK : T_PAY;
      end
      T_PAY: begin
        w_data = tx_pay_byte;
        if (wr_uart && tx_idx == tx_req.len - 1'b1) tx_nxt = T_CHK;
      end
      T_CHK: begin
        w_data = tx_chk;
        if (wr_uart) tx_nxt = T_IDLE;
      end
      default: tx_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st     <= T_IDLE;
      tx_req    <= '0;
      tx_idx    <= '0;
      send_done <= 1'b0;
    end else begin
      tx_st     <= tx_nxt;
      send_done <= (tx_st == T_CHK) && wr_uart;
      if (tx_st == T_IDLE && send_req)
        tx_req <= '{typ: send_type,
                    len: (send_len > MAX_L) ? MAX_L : send_len,
                    pay: send_payload};
      if (wr_uart) begin
        if (tx_st == T_LEN)      tx_idx <= '0;
        else if (tx_st == T_PAY) tx_idx <= tx_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_codec.sv
// Bench for uart_frame_codec: directed vector table, backpressure/reset sequences,
// and a randomized concurrent RX/TX run checked against a frame-level model.
module tb_uart_frame_codec;
  localparam int MAX_LEN = 4;
  localparam int LEN_W   = 3;
  localparam int PW      = 8*MAX_LEN;

  logic             clk = 0, rst = 1;
  logic             rx_empty = 1, tx_full = 0, send_req = 0;
  logic [7:0]       r_data = 0, send_type = 0;
  logic [LEN_W-1:0] send_len = 0;
  logic [PW-1:0]    send_payload = 0;
  logic             rd_uart, wr_uart, frm_valid, frm_err, send_busy, send_done;
  logic [7:0]       w_data, frm_type;
  logic [LEN_W-1:0] frm_len;
  logic [PW-1:0]    frm_payload;

  always #5 clk = ~clk;

  uart_frame_codec #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .SOF(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
    .frm_valid(frm_valid), .frm_err(frm_err), .frm_type(frm_type), .frm_len(frm_len),
    .frm_payload(frm_payload), .send_req(send_req), .send_type(send_type),
    .send_len(send_len), .send_payload(send_payload), .send_busy(send_busy),
    .send_done(send_done));

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic             err;
    logic [7:0]       typ;
    logic [LEN_W-1:0] len;
    logic [PW-1:0]    pay;
  } ev_t;
  typedef struct {
    logic [79:0]      b;    // bytes, first byte in the top octet
    int               n;
    int               nv;
    int               ne;
    logic [7:0]       typ;
    logic [LEN_W-1:0] len;
    logic [PW-1:0]    pay;
  } rx_vec_t;

  ev_t        rx_ev[$], exp_ev[$];
  logic [7:0] tx_q[$], exp_tx[$];
  int         tx_cyc[$];
  int         n_cmp = 0, n_bad = 0;
  int         n_done = 0, n_busy = 0, n_viol = 0, cyc = 0;
  bit         full_rand = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Output monitor, sampled away from the active edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (wr_uart) begin
      tx_q.push_back(w_data);
      tx_cyc.push_back(cyc);
      if (tx_full) n_viol++;
    end
    if (send_busy) n_busy++;
    if (send_done) n_done++;
    if (frm_valid) rx_ev.push_back('{1'b0, frm_type, frm_len, frm_payload});
    if (frm_err)   rx_ev.push_back('{1'b1, 8'h00, '0, '0});
  end

  initial forever begin
    @(posedge clk); #1;
    tx_full = full_rand ? 1'($urandom_range(1)) : 1'b0;
  end

  task automatic rx_feed(input bq_t q, input int gap_pct);
    foreach (q[i]) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        rx_empty = 1; @(posedge clk); #1;
      end
      rx_empty = 0; r_data = q[i];
      @(posedge clk); #1;
    end
    rx_empty = 1;
  endtask

  task automatic tx_send(input logic [7:0] t, input logic [LEN_W-1:0] l,
                         input logic [PW-1:0] p, input bit noise);
    int k, d0;
    k = 0;
    while (send_busy && k < 200) begin @(posedge clk); #1; k++; end
    d0 = n_done;
    send_req = 1; send_type = t; send_len = l; send_payload = p;
    @(posedge clk); #1;
    send_req = 0;
    k = 0;
    while (n_done == d0 && k < 300) begin
      // Requests while busy must be ignored; only raise them in a busy cycle.
      send_req = noise && send_busy && ($urandom_range(2) == 0);
      if (send_req) begin send_type = 8'hEE; send_len = 3'd3; end
      @(posedge clk); #1; k++;
    end
    send_req = 0;
    chk("tx_done_in_time", 64'(k < 300), 64'd1);
  endtask

  // Frame-level reference: scan the byte stream and list the expected outcomes.
  function automatic void rx_model(input bq_t s);
    int i, ln;
    logic [7:0] t, l, sum;
    logic [PW-1:0] p;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) i++;
      else if (i + 2 >= s.size()) i = s.size();
      else begin
        t = s[i+1]; l = s[i+2]; ln = int'(l); i += 3;
        if (ln > MAX_LEN) exp_ev.push_back('{1'b1, 8'h00, '0, '0});
        else if (i + ln >= s.size()) i = s.size();
        else begin
          sum = t + l; p = '0;
          for (int k = 0; k < ln; k++) begin p[8*k +: 8] = s[i+k]; sum += s[i+k]; end
          sum += s[i+ln];
          if (sum == 8'h00) exp_ev.push_back('{1'b0, t, l[LEN_W-1:0], p});
          else              exp_ev.push_back('{1'b1, 8'h00, '0, '0});
          i += ln + 1;
        end
      end
    end
  endfunction

  function automatic void tx_model(input logic [7:0] t, input logic [LEN_W-1:0] l,
                                   input logic [PW-1:0] p);
    int ln;
    logic [7:0] sum;
    ln = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
    sum = t + 8'(ln);
    exp_tx.push_back(8'hA5); exp_tx.push_back(t); exp_tx.push_back(8'(ln));
    for (int k = 0; k < ln; k++) begin exp_tx.push_back(p[8*k +: 8]); sum += p[8*k +: 8]; end
    exp_tx.push_back(8'h00 - sum);
  endfunction

  rx_vec_t    tab[6];
  bq_t        s;
  logic [7:0] rt[12];
  logic [LEN_W-1:0] rl[12];
  logic [PW-1:0] rp[12];
  logic [39:0] ex5;

  initial begin
    int nv, ne, b0, d0, v0, e0, span, kind, ln;
    logic [7:0] t, sum, bt;

    tab[0] = '{80'hA5120234566200000000, 6, 1, 0, 8'h12, 3'd2, 32'h00005634};
    tab[1] = '{80'h00FFA50100FF00000000, 6, 1, 0, 8'h01, 3'd0, 32'h00000000};
    tab[2] = '{80'hA5120234566300000000, 6, 0, 1, 8'h01, 3'd0, 32'h00000000};
    tab[3] = '{80'hA5070500000000000000, 3, 0, 1, 8'h01, 3'd0, 32'h00000000};
    tab[4] = '{80'hA5330401020304BF0000, 8, 1, 0, 8'h33, 3'd4, 32'h04030201};
    tab[5] = '{80'hA5A501A5B50000000000, 5, 1, 0, 8'hA5, 3'd1, 32'h000000A5};
    ex5 = 40'hA520010AD5;

    // Reset state; a non-empty RX FIFO must not be popped while in reset.
    rx_empty = 0; r_data = 8'hA5;
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", 64'({rd_uart, wr_uart, w_data, frm_valid, frm_err, frm_type,
                              frm_len, frm_payload, send_busy, send_done}), 64'd0);
    rst = 0; rx_empty = 1;
    @(posedge clk); #1;

    foreach (tab[v]) begin
      s = {};
      for (int i = 0; i < tab[v].n; i++) s.push_back(tab[v].b[79-8*i -: 8]);
      rx_ev.delete();
      rx_feed(s, 0);
      repeat (3) @(posedge clk); #1;
      nv = 0; ne = 0;
      foreach (rx_ev[k]) if (rx_ev[k].err) ne++; else nv++;
      chk($sformatf("vec%0d_valid_cnt", v), 64'(nv), 64'(tab[v].nv));
      chk($sformatf("vec%0d_err_cnt", v), 64'(ne), 64'(tab[v].ne));
      chk($sformatf("vec%0d_type", v), 64'(frm_type), 64'(tab[v].typ));
      chk($sformatf("vec%0d_len", v), 64'(frm_len), 64'(tab[v].len));
      chk($sformatf("vec%0d_payload", v), 64'(frm_payload), 64'(tab[v].pay));
    end

    // Single send without backpressure.
    tx_q.delete(); tx_cyc.delete(); b0 = n_busy; d0 = n_done;
    tx_send(8'h20, 3'd1, 32'h0A, 0);
    repeat (2) @(posedge clk); #1;
    chk("s4_nbytes", 64'(tx_q.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("s4_byte%0d", i), (i < tx_q.size()) ? 64'(tx_q[i]) : 64'hFFFF,
          64'(ex5[39-8*i -: 8]));
    span = (tx_cyc.size() == 5) ? tx_cyc[4] - tx_cyc[0] : -1;
    chk("s4_consecutive", 64'(span), 64'd4);
    chk("s4_busy_cycles", 64'(n_busy - b0), 64'd5);
    chk("s4_done_pulses", 64'(n_done - d0), 64'd1);

    // Same send under random backpressure with ignored requests while busy.
    full_rand = 1;
    tx_q.delete(); v0 = n_viol; d0 = n_done;
    tx_send(8'h20, 3'd1, 32'h0A, 1);
    repeat (2) @(posedge clk); #1;
    chk("s5_nbytes", 64'(tx_q.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("s5_byte%0d", i), (i < tx_q.size()) ? 64'(tx_q[i]) : 64'hFFFF,
          64'(ex5[39-8*i -: 8]));
    chk("s5_push_while_full", 64'(n_viol - v0), 64'd0);
    chk("s5_done_pulses", 64'(n_done - d0), 64'd1);

    // Reset in the middle of a frame in both directions.
    full_rand = 0;
    repeat (2) @(posedge clk); #1;
    tx_q.delete();
    send_req = 1; send_type = 8'h20; send_len = 3'd1; send_payload = 32'h0A;
    rx_empty = 0; r_data = 8'hA5;
    @(posedge clk); #1;
    send_req = 0; r_data = 8'h12;
    @(posedge clk); #1;
    rx_empty = 1;
    @(posedge clk); #1;
    chk("s6_pushed_before_rst", 64'(tx_q.size()), 64'd2);
    e0 = rx_ev.size(); d0 = n_done;
    rst = 1;
    @(posedge clk); #1;
    chk("s6_outputs_after_rst", 64'({rd_uart, wr_uart, w_data, frm_valid, frm_err, frm_type,
                                    frm_len, frm_payload, send_busy, send_done}), 64'd0);
    rst = 0;
    repeat (5) @(posedge clk); #1;
    chk("s6_no_rx_pulse", 64'(rx_ev.size()), 64'(e0));
    chk("s6_no_done_pulse", 64'(n_done), 64'(d0));
    s = {8'hA5, 8'h12, 8'h02, 8'h34, 8'h56, 8'h62};
    tx_q.delete(); rx_ev.delete();
    fork
      rx_feed(s, 0);
      tx_send(8'h20, 3'd1, 32'h0A, 0);
    join
    repeat (3) @(posedge clk); #1;
    chk("s6_rx_events", 64'(rx_ev.size()), 64'd1);
    chk("s6_rx_frame", 64'({frm_type, frm_len, frm_payload}), 64'({8'h12, 3'd2, 32'h00005634}));
    chk("s6_tx_bytes", 64'(tx_q.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("s6_byte%0d", i), (i < tx_q.size()) ? 64'(tx_q[i]) : 64'hFFFF,
          64'(ex5[39-8*i -: 8]));

    // Randomized concurrent traffic against the frame-level model.
    s = {};
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(2)) s.push_back(8'($urandom_range(8'hA4)));
      kind = $urandom_range(9);
      t = 8'($urandom);
      s.push_back(8'hA5); s.push_back(t);
      if (kind == 0) s.push_back(8'($urandom_range(255, MAX_LEN + 1)));
      else begin
        ln = $urandom_range(MAX_LEN);
        s.push_back(8'(ln));
        sum = t + 8'(ln);
        for (int k = 0; k < ln; k++) begin
          bt = 8'($urandom); s.push_back(bt); sum += bt;
        end
        s.push_back((kind == 1) ? 8'h01 - sum : 8'h00 - sum);
      end
    end
    exp_ev.delete(); rx_model(s);
    exp_tx.delete();
    for (int i = 0; i < 12; i++) begin
      rt[i] = 8'($urandom); rl[i] = LEN_W'($urandom_range(7)); rp[i] = PW'($urandom);
      tx_model(rt[i], rl[i], rp[i]);
    end
    full_rand = 1;
    tx_q.delete(); rx_ev.delete(); v0 = n_viol;
    fork
      rx_feed(s, 30);
      for (int i = 0; i < 12; i++) tx_send(rt[i], rl[i], rp[i], 1);
    join
    repeat (5) @(posedge clk); #1;
    chk("rnd_rx_event_count", 64'(rx_ev.size()), 64'(exp_ev.size()));
    foreach (exp_ev[i])
      chk($sformatf("rnd_rx_ev%0d", i), (i < rx_ev.size()) ? 64'(rx_ev[i]) : 64'hFFFF_FFFF_FFFF,
          64'(exp_ev[i]));
    chk("rnd_tx_byte_count", 64'(tx_q.size()), 64'(exp_tx.size()));
    foreach (exp_tx[i])
      chk($sformatf("rnd_tx_byte%0d", i), (i < tx_q.size()) ? 64'(tx_q[i]) : 64'hFFFF,
          64'(exp_tx[i]));
    chk("rnd_push_while_full", 64'(n_viol - v0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
